// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// State encoding, RV32I size codes and the request bundle.
package data_mem_responder_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int WAIT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic                  write;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32I loads and stores.
// Also flags misaligned and illegal size/sign codes.
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]            addr_lo,
  input  logic [2:0]            funct3,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rword,
  output logic [3:0]            be,
  output logic [DATA_WIDTH-1:0] wdata_sh,
  output logic                  bad,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic       is_b;
  logic       is_h;
  logic       is_w;
  logic       uns;
  logic       illegal;
  logic       misalign;
  logic [7:0] rbyte;
  logic [15:0] rhalf;

  assign is_b = (funct3[1:0] == F3_B[1:0]);
  assign is_h = (funct3[1:0] == F3_H[1:0]);
  assign is_w = (funct3[1:0] == F3_W[1:0]);
  assign uns  = funct3[2];

  // 011, 110, 111 never legal; unsigned codes are load-only
  assign illegal = (funct3[1:0] == 2'b11)
                 | (funct3 == 3'b110)
                 | (write & uns);
  assign misalign = (is_h & addr_lo[0])
                  | (is_w & (|addr_lo));
  assign bad = illegal | misalign;

  assign rbyte = rword[{addr_lo, 3'b000} +: 8];
  assign rhalf = addr_lo[1] ? rword[31:16]
                            : rword[15:0];

  always_comb begin
    be       = 4'b1111;
    wdata_sh = wdata;
    rdata    = rword;
    unique case (1'b1)
      is_b: begin
        be       = 4'b0001 << addr_lo;
        wdata_sh = {4{wdata[7:0]}};
        rdata    = {{24{rbyte[7] & ~uns}}, rbyte};
      end
      is_h: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {2{wdata[15:0]}};
        rdata    = {{16{rhalf[15] & ~uns}}, rhalf};
      end
      default: begin
        be       = 4'b1111;
        wdata_sh = wdata;
        rdata    = rword;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder with fixed wait states over
// valid/ready request and response channels.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_error_o
);

  localparam int IDX_W =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT =
    WAIT_W'(WAIT_CYCLES);

  state_e                state_q;
  state_e                state_d;
  logic [WAIT_W-1:0]     cnt_q;
  mem_req_t              req_q;
  mem_req_t              req_in;
  mem_req_t              req_cur;
  logic                  accept;
  logic                  rsp_hs;
  logic                  enter_resp;
  logic                  oor;
  logic                  err;
  logic                  bad;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] rword;
  logic [IDX_W-1:0]      idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  assign req_in = '{
    write:  req_write_i,
    funct3: req_funct3_i,
    addr:   req_addr_i,
    wdata:  req_wdata_i
  };

  // With zero wait states the access runs straight off the inputs
  assign req_cur = (state_q == IDLE) ? req_in : req_q;

  assign accept     = req_valid_i & req_ready_o;
  assign rsp_hs     = rsp_valid_o & rsp_ready_i;
  assign enter_resp = (state_d == RESP) & (state_q != RESP);

  assign idx = req_cur.addr[IDX_W+1:2];
  assign oor = req_cur.addr[DATA_WIDTH-1:2]
             >= (DATA_WIDTH-2)'(DEPTH_WORDS);
  assign rword = mem[idx];
  assign err = bad | oor;

  mem_lane_align u_align (
    .addr_lo  (req_cur.addr[1:0]),
    .funct3   (req_cur.funct3),
    .write    (req_cur.write),
    .wdata    (req_cur.wdata),
    .rword    (rword),
    .be       (be),
    .wdata_sh (wdata_sh),
    .bad      (bad),
    .rdata    (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_valid_i)
              state_d = (WAIT_CYCLES == 0) ? RESP : BUSY;
      BUSY: if (cnt_q == WAIT_W'(1)) state_d = RESP;
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    rsp_valid_o = (state_q == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      req_q <= '0;
    end else if (accept) begin
      cnt_q <= WAIT_INIT;
      req_q <= req_in;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q - WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
    end else if (enter_resp) begin
      rsp_error_o <= err;
      rsp_rdata_o <= (err | req_cur.write) ? '0 : ld_data;
    end else if (rsp_hs) begin
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
    end
  end

  // Storage is never cleared; reset only blocks the write
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n && enter_resp && req_cur.write && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

endmodule
